// File: rtl/bs_gnrtr_n_rbtr_pkg.sv
// Shared types and constants for the bus generator / arbiter.
package bs_gnrtr_n_rbtr_pkg;

    // Width of the destination-ID field at the top of every packet.
    localparam int unsigned ID_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DELIVER = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bs_gnrtr_n_rbtr_if.sv
// Bundle of per-bus device handshake signals shared by the arbiter and devices.
interface bus_if #(
    parameter int bits    = 1,
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
) (
    input logic clk
);

    logic                                   reset;
    logic [bits-1:0][drvrs-1:0]             pndng;
    logic [bits-1:0][drvrs-1:0]             push;
    logic [bits-1:0][drvrs-1:0]             pop;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;

    // Arbiter side: reads device FIFO status, issues pop/push.
    modport master (
        input  clk, reset, pndng, D_pop,
        output pop, push, D_push
    );

    // Device side: presents FIFO heads, receives pop/push.
    modport slave (
        input  clk, pop, push, D_push,
        output reset, pndng, D_pop
    );

endinterface

// File: rtl/bs_gnrtr_n_rbtr_arbiter.sv
// Single-bus round-robin arbiter: IDLE -> GRANT (pop) -> DELIVER (push).
// Broadcast delivery is compiled in only with BUS_BROADCAST_EN defined.
module bus_arbiter
    import bs_gnrtr_n_rbtr_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);

    localparam int unsigned N     = drvrs;
    localparam int unsigned PTR_W = (drvrs > 1) ? $clog2(drvrs) : 1;
`ifdef BUS_BROADCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   src_q, src_d;
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic [pckg_sz-1:0] dpush_q, dpush_d;

    logic [pckg_sz-1:0] pkt;
    logic [ID_W-1:0]    dest;
    logic [drvrs-1:0]   fwd;
    logic               found;
    int unsigned        cand;

    // Next-state: round-robin pick in IDLE, route decode in GRANT, pointer advance in DELIVER.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        pop_d   = '0;
        push_d  = '0;
        dpush_d = dpush_q;
        pkt     = D_pop[src_q];
        dest    = pkt[pckg_sz-1 -: ID_W];
        fwd     = '0;
        found   = 1'b0;
        cand    = 0;
        unique case (state_q)
            IDLE: begin
                for (int unsigned off = 0; off < N; off++) begin
                    cand = (32'(ptr_q) + off) % N;
                    if (!found && pndng[PTR_W'(cand)]) begin
                        found = 1'b1;
                        src_d = PTR_W'(cand);
                    end
                end
                if (found) begin
                    pop_d[src_d] = 1'b1;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if (BCAST_EN && dest == broadcast) begin
                    fwd         = '1;
                    fwd[src_q]  = 1'b0;
                end else if (32'(dest) < N) begin
                    fwd[PTR_W'(dest)] = 1'b1;
                end
                // D_push only reloads when something is actually delivered.
                if (|fwd) begin
                    push_d  = fwd;
                    dpush_d = pkt;
                end
                state_d = DELIVER;
            end
            DELIVER: begin
                ptr_d   = PTR_W'((32'(src_q) + 1) % N);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            dpush_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            dpush_q <= dpush_d;
        end
    end

    // Strobes are masked while reset is high so an aborted transfer never pops or pushes.
    assign pop    = pop_q  & {drvrs{~reset}};
    assign push   = push_q & {drvrs{~reset}};
    assign D_push = {drvrs{dpush_q}};

endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// Multi-bus packet generator/arbiter top: one bus_arbiter per bus.
// Optional broadcast delivery: define BUS_BROADCAST_EN.
module bs_gnrtr_n_rbtr
    import bs_gnrtr_n_rbtr_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic  clk,
    input  logic  reset,
    bus_if.master bus
);

    logic [bits-1:0][drvrs-1:0]              pop_w;
    logic [bits-1:0][drvrs-1:0]              push_w;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] dpush_w;

    // One independent arbiter per bus.
    for (genvar b = 0; b < bits; b++) begin : g_bus
        bus_arbiter #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_arb (
            .clk    (clk),
            .reset  (reset),
            .pndng  (bus.pndng[b]),
            .D_pop  (bus.D_pop[b]),
            .pop    (pop_w[b]),
            .push   (push_w[b]),
            .D_push (dpush_w[b])
        );
    end

    assign bus.pop    = pop_w;
    assign bus.push   = push_w;
    assign bus.D_push = dpush_w;

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Scoreboard bench for bs_gnrtr_n_rbtr (bits=1, drvrs=4, pckg_sz=16).
module tb_bs_gnrtr_n_rbtr;

    typedef struct {
        int         t;
        logic [3:0] mask;
        logic [15:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_if #(.bits(1), .drvrs(4), .pckg_sz(16)) bus (.clk(clk));
    assign bus.reset = reset;

    bs_gnrtr_n_rbtr #(
        .bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] fq [4][$];
    ev_t exp_pop [$];
    ev_t exp_push[$];
    int  grant_log[$];
    logic [3:0]  pop_seen = '0;
    logic [15:0] exp_last = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < 4; i++) begin
            bus.pndng[0][i] = (fq[i].size() != 0);
            bus.D_pop[0][i] = (fq[i].size() != 0) ? fq[i][0] : 16'h0000;
        end
    endtask

    task automatic enq(input int i, input logic [15:0] d);
        fq[i].push_back(d);
        drive_bus();
    endtask

    // Advance one clock; devices retire the head popped during the previous cycle.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (pop_seen[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        drive_bus();
    endtask

    // Reference model: transaction-level round robin with a 3-cycle service slot.
    int  m_ptr = 0;
    int  free_at = 0;
    int  m_w, m_c;
    bit  m_found;
    bit  m_bc;
    ev_t m_e;
    logic [7:0]  m_dest;
    logic [15:0] m_pkt;
    logic [3:0]  m_mask;
    always @(posedge clk) begin
        cyc++;
`ifdef BUS_BROADCAST_EN
        m_bc = 1'b1;
`else
        m_bc = 1'b0;
`endif
        if (reset) begin
            m_ptr   = 0;
            free_at = 0;
            exp_pop.delete();
            exp_push.delete();
        end else if (cyc >= free_at) begin
            m_found = 1'b0;
            m_w     = 0;
            for (int k = 0; k < 4; k++) begin
                m_c = (m_ptr + k) % 4;
                if (!m_found && fq[m_c].size() != 0) begin
                    m_found = 1'b1;
                    m_w     = m_c;
                end
            end
            if (m_found) begin
                m_pkt  = fq[m_w][0];
                m_dest = m_pkt[15:8];
                m_e.t    = cyc;
                m_e.mask = 4'(1 << m_w);
                m_e.data = m_pkt;
                exp_pop.push_back(m_e);
                if (m_bc && m_dest == 8'hFF)  m_mask = 4'hF & ~(4'(1 << m_w));
                else if (m_dest < 8'd4)       m_mask = 4'(1 << m_dest);
                else                          m_mask = 4'h0;
                if (m_mask != 0) begin
                    m_e.t    = cyc + 1;
                    m_e.mask = m_mask;
                    exp_push.push_back(m_e);
                end
                m_ptr   = (m_w + 1) % 4;
                free_at = cyc + 3;
            end
        end
    end

    // Monitor: sample mid-cycle and compare against the scoreboard.
    ev_t mo_e;
    always @(negedge clk) begin
        pop_seen = bus.pop[0];
        for (int i = 0; i < 4; i++)
            if (bus.pop[0][i]) grant_log.push_back(i);
        if (reset) begin
            chk("rst_pop",  64'(bus.pop[0]),  64'h0);
            chk("rst_push", 64'(bus.push[0]), 64'h0);
            exp_last = '0;
        end else begin
            while (exp_pop.size() > 0 && exp_pop[0].t < cyc) begin
                chk("pop_missed", 64'h1, 64'h0);
                void'(exp_pop.pop_front());
            end
            if (exp_pop.size() > 0 && exp_pop[0].t == cyc) begin
                mo_e = exp_pop.pop_front();
                chk("pop_mask", 64'(bus.pop[0]), 64'(mo_e.mask));
            end else begin
                chk("pop_idle", 64'(bus.pop[0]), 64'h0);
            end
            while (exp_push.size() > 0 && exp_push[0].t < cyc) begin
                chk("push_missed", 64'h1, 64'h0);
                void'(exp_push.pop_front());
            end
            if (exp_push.size() > 0 && exp_push[0].t == cyc) begin
                mo_e = exp_push.pop_front();
                chk("push_mask", 64'(bus.push[0]), 64'(mo_e.mask));
                chk("dpush_data", bus.D_push[0], {4{mo_e.data}});
                exp_last = mo_e.data;
            end else begin
                chk("push_idle", 64'(bus.push[0]), 64'h0);
                chk("dpush_hold", bus.D_push[0], {4{exp_last}});
            end
        end
    end

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int sel;

    initial begin
        reset = 1'b1;
        drive_bus();
        repeat (2) step();
        chk("rst_dpush", bus.D_push[0], 64'h0);
        reset = 1'b0;
        repeat (3) step();

        // Unicast from device 1 to device 2.
        enq(1, 16'h02AB);
        repeat (6) step();
        // Broadcast from device 0.
        enq(0, 16'hFF55);
        repeat (6) step();
        // Out-of-range destination: popped, dropped.
        enq(3, 16'h0712);
        repeat (6) step();
        chk("drop_popped", 64'(fq[3].size()), 64'h0);

        // Reset during the DELIVER cycle.
        enq(2, 16'h0033);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("abort_popped", 64'(fq[2].size()), 64'h0);

        // All four requesting: round-robin order from ptr 0.
        grant_log.delete();
        for (int i = 0; i < 4; i++)
            for (int r = 0; r < 2; r++)
                fq[i].push_back({8'((i + 1) % 4), 8'($urandom)});
        drive_bus();
        repeat (30) step();
        chk("rr_count", 64'(grant_log.size()), 64'd8);
        if (grant_log.size() >= 5)
            for (int k = 0; k < 5; k++)
                chk("rr_order", 64'(grant_log[k]), 64'(exp_order[k]));

        // Randomized traffic with occasional resets.
        repeat (500) begin
            step();
            if ($urandom_range(0, 99) < 35) begin
                sel = $urandom_range(0, 3);
                if (fq[sel].size() < 4) begin
                    case ($urandom_range(0, 7))
                        0, 1, 2, 3: enq(sel, {8'($urandom_range(0, 3)), 8'($urandom)});
                        4:          enq(sel, {8'hFF, 8'($urandom)});
                        5:          enq(sel, {8'h07, 8'($urandom)});
                        6:          enq(sel, {8'h04, 8'($urandom)});
                        default:    enq(sel, 16'($urandom));
                    endcase
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
        end

        repeat (40) step();
        chk("drain_sb", 64'(exp_pop.size() + exp_push.size()), 64'h0);
        chk("drain_fifo", 64'(fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bs_gnrtr_n_rbtr.md
BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

Interface
REQ-001 The module SHALL have parameter bits, default 1, meaning the number of independent buses.
REQ-002 The module SHALL have parameter drvrs, default 4, meaning the number of devices per bus (at most 255).
REQ-003 The module SHALL have parameter pckg_sz, default 16, meaning the packet width in bits (at least 9).
REQ-004 The module SHALL have parameter broadcast, default 8'hFF, meaning the destination ID that addresses all devices.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port pndng, input, [bits-1:0][drvrs-1:0]: the device FIFO holds a packet to send.
REQ-008 The module SHALL have port D_pop, input, [bits-1:0][drvrs-1:0][pckg_sz-1:0]: head-of-FIFO data from each device (first-word fall-through).
REQ-009 The module SHALL have port pop, output, [bits-1:0][drvrs-1:0]: removes the head packet from the device FIFO.
REQ-010 The module SHALL have port push, output, [bits-1:0][drvrs-1:0]: writes D_push into the device input FIFO.
REQ-011 The module SHALL have port D_push, output, [bits-1:0][drvrs-1:0][pckg_sz-1:0]: delivered packet data.

Function
REQ-012 Each bus SHALL operate independently with its own state machine and round-robin pointer.
REQ-013 The packet format SHALL be destination ID in bits [pckg_sz-1:pckg_sz-8] and payload in the remaining bits.
REQ-014 The state machine SHALL have three states: IDLE, GRANT, DELIVER.
REQ-015 IDLE SHALL select the first index i, searching from ptr upward with wrap-around, for which pndng[b][i]=1, then go to GRANT; if none, it SHALL stay in IDLE.
REQ-016 GRANT SHALL assert pop[b][i] for exactly one cycle and capture D_pop[b][i] on that edge.
REQ-017 DELIVER SHALL drive the captured packet on D_push[b][k] for all k.
REQ-018 In DELIVER, if dest < drvrs, the module SHALL assert push[b][dest] only, for one cycle.
REQ-019 In DELIVER, if dest == broadcast, the module SHALL assert push[b][k] for every k except the source i, for one cycle.
REQ-020 In DELIVER, if dest is out of range and not broadcast, the packet SHALL be dropped with no push.
REQ-021 Self-addressed packets (dest == i) SHALL be delivered normally.
REQ-022 After DELIVER, the module SHALL set ptr to (i+1) mod drvrs and return to IDLE.
REQ-023 Latency SHALL be: pndng sampled high at edge N, pop high during cycle N+1, push high during cycle N+2, new arbitration from edge N+3, i.e. at most one packet per 3 cycles per bus.
REQ-024 pndng changes during GRANT or DELIVER SHALL be ignored until IDLE.
REQ-025 Simultaneous requests SHALL be served in round-robin order, with no device starved.
REQ-026 D_push SHALL hold its last value when push is low.

Reset
REQ-027 On reset=1 at a rising edge, all pop, push and D_push outputs SHALL be 0, every ptr SHALL be 0 and every state SHALL be IDLE.
REQ-028 Reset mid-GRANT or mid-DELIVER SHALL abort the transfer, with no push issued for that packet.

Configuration
REQ-029 With macro BUS_BROADCAST_EN defined, broadcast delivery SHALL follow REQ-019.
REQ-030 Without BUS_BROADCAST_EN, a broadcast ID SHALL be treated as out of range and dropped per REQ-020.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, GRANT, DELIVER) and the ID-field width constant (8).
REQ-032 The top module SHALL instantiate one sub-module, bus_arbiter, per bus via a generate loop.
REQ-033 The interface bus_if SHALL carry clk as a port and reset, pndng, push, pop, D_pop, D_push with identical parameters and widths.

Verification (bits=1, drvrs=4, pckg_sz=16)
REQ-034 Scenario: reset held for 2 cycles -> all outputs 0 and no pop while pndng=0.
REQ-035 Scenario: pndng[1]=1 with D_pop[1]=16'h02AB -> pop[1] pulses for one cycle, then push[2] pulses with D_push=16'h02AB.
REQ-036 Scenario: pndng[0]=1 with D_pop[0]=16'hFF55 -> push on devices 1, 2 and 3, not 0; without BUS_BROADCAST_EN, no push.
REQ-037 Scenario: D_pop[3]=16'h0712 (dest 7) -> pop[3] pulses and no push occurs.
REQ-038 Scenario: pndng=4'b1111 held -> grants in order 0, 1, 2, 3, 0, with one pop every 3 cycles.
REQ-039 Scenario: reset asserted during the DELIVER cycle -> no push and state IDLE.
